// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 16-bit, 4-register CPU: steps FETCH/DECODE/EXEC/WB,
// drives all datapath selects and strobes, halts on illegal opcode or fetch timeout.
module multicycle_control #(
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctl,
  output logic             reg_dst,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_ADDI  = 4'b0111;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [3:0]       r_op;
  logic [7:0]       r_tmo;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_retired;
  logic             w_tmo_hit;
  logic             w_legal;

  assign w_tmo_hit = (r_tmo == 8'(FETCH_TIMEOUT - 1));
  assign w_legal   = ~op[3];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_op      <= 4'd0;
      r_tmo     <= 8'd0;
      r_cause   <= 2'b00;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FETCH: begin
          r_tmo <= mem_ready ? 8'd0 : r_tmo + 8'd1;
          if (!mem_ready && w_tmo_hit) r_cause <= 2'b10;
        end
        S_DECODE: begin
          r_op <= op;
          if (!w_legal) r_cause <= 2'b01;
        end
        S_WB:    r_retired <= r_retired + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : (w_tmo_hit ? S_HALT : S_FETCH);
      S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_ctl   = 4'b0010;
    reg_dst   = 1'b0;
    reg_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      // WB keeps the EXEC operand/op selects so the ALU result stays stable.
      S_EXEC, S_WB: begin
        alu_src_a = 1'b1;
        alu_src_b = (r_op == OP_ADDI) ? 2'b10 : 2'b00;
        reg_dst   = (r_op != OP_ADDI);
        reg_write = (r_state == S_WB);
        case (r_op)
          4'b0000: alu_ctl = 4'b0010;
          4'b0001: alu_ctl = 4'b0110;
          4'b0010: alu_ctl = 4'b0000;
          4'b0011: alu_ctl = 4'b0001;
          4'b0100: alu_ctl = 4'b1100;
          4'b0101: alu_ctl = 4'b1101;
          4'b0110: alu_ctl = 4'b0111;
          default: alu_ctl = 4'b0010;
        endcase
      end
      default: ;
    endcase
    if (reset) begin
      mem_req   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state      = r_state;
  assign halted     = (r_state == S_HALT);
  assign halt_cause = r_cause;
  assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction transaction model predicts
// state sequence, strobes and ALU selects; second instance covers CNT_W=2 / FETCH_TIMEOUT=1.
module tb_multicycle_control;

  logic        clock = 1'b0;
  logic        reset, mem_ready;
  logic [3:0]  op;
  logic        mem_req, ir_write, pc_write, alu_src_a, reg_dst, reg_write, halted;
  logic [1:0]  alu_src_b, halt_cause;
  logic [3:0]  alu_ctl;
  logic [2:0]  state;
  logic [15:0] retired;

  logic        reset2, mem_ready2;
  logic [3:0]  op2;
  logic        mem_req2, ir_write2, pc_write2, alu_src_a2, reg_dst2, reg_write2, halted2;
  logic [1:0]  alu_src_b2, halt_cause2;
  logic [3:0]  alu_ctl2;
  logic [2:0]  state2;
  logic [1:0]  retired2;

  int checks = 0;
  int errors = 0;
  int m_retired = 0;
  logic [3:0] alu_tab [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                              4'b1100, 4'b1101, 4'b0111, 4'b0010};

  // {state, mem_req, ir_write, pc_write, reg_write, alu_ctl, halted, halt_cause}
  wire [13:0] sv   = {state, mem_req, ir_write, pc_write, reg_write, alu_ctl, halted, halt_cause};
  wire [2:0]  srcv = {alu_src_a, alu_src_b};

  always #5 clock = ~clock;

  multicycle_control dut (
    .clock(clock), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .ir_write(ir_write), .pc_write(pc_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
    .reg_dst(reg_dst), .reg_write(reg_write), .state(state), .halted(halted),
    .halt_cause(halt_cause), .retired(retired)
  );

  multicycle_control #(.CNT_W(2), .FETCH_TIMEOUT(1)) dut2 (
    .clock(clock), .reset(reset2), .op(op2), .mem_ready(mem_ready2),
    .mem_req(mem_req2), .ir_write(ir_write2), .pc_write(pc_write2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_ctl(alu_ctl2),
    .reg_dst(reg_dst2), .reg_write(reg_write2), .state(state2), .halted(halted2),
    .halt_cause(halt_cause2), .retired(retired2)
  );

  function automatic logic [13:0] vec(input logic [2:0] s, input logic [3:0] strb,
                                      input logic [3:0] ctl, input logic h, input logic [1:0] c);
    return {s, strb, ctl, h, c};
  endfunction

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Reset is held across two edges; strobes must be masked while FETCH would assert them.
  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'(($urandom & 1) | 1); op = 4'($urandom);
    step(); #3;
    checks++;
    if (sv !== vec(3'd0, 4'b0000, 4'b0010, 1'b0, 2'b00) || retired !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: sv=%b retired=%0d, want sv=%b retired=0",
               sv, retired, vec(3'd0, 4'b0000, 4'b0010, 1'b0, 2'b00));
    end
    step();
    reset = 1'b0;
    m_retired = 0;
  endtask

  // One instruction: 'waits' cycles of mem_ready=0 in FETCH, then the rest at full speed.
  task automatic run_instr(input logic [3:0] o, input int waits);
    logic [2:0] src;
    src = {1'b1, (o == 4'b0111) ? 2'b10 : 2'b00};
    for (int w = 0; w < waits; w++) begin
      mem_ready = 1'b0; #3;
      checks++;
      if (sv !== vec(3'd0, 4'b1000, 4'b0010, 1'b0, 2'b00) || srcv !== 3'b001) begin
        errors++;
        $display("FAIL fetch_wait[%0d]: sv=%b src=%b, want sv=%b src=001",
                 w, sv, srcv, vec(3'd0, 4'b1000, 4'b0010, 1'b0, 2'b00));
      end
      step();
    end
    mem_ready = 1'b1; #3;
    checks++;
    if (sv !== vec(3'd0, 4'b1110, 4'b0010, 1'b0, 2'b00) || srcv !== 3'b001) begin
      errors++;
      $display("FAIL fetch_accept: sv=%b src=%b, want sv=%b src=001",
               sv, srcv, vec(3'd0, 4'b1110, 4'b0010, 1'b0, 2'b00));
    end
    step();
    op = o; mem_ready = 1'($urandom); #3;
    checks++;
    if (sv !== vec(3'd1, 4'b0000, 4'b0010, 1'b0, 2'b00)) begin
      errors++;
      $display("FAIL decode: sv=%b, want %b", sv, vec(3'd1, 4'b0000, 4'b0010, 1'b0, 2'b00));
    end
    step();
    if (o[3]) begin
      op = 4'($urandom); #3;
      checks++;
      if (sv !== vec(3'd4, 4'b0000, 4'b0010, 1'b1, 2'b01) || retired !== 16'(m_retired)) begin
        errors++;
        $display("FAIL illegal_halt: sv=%b retired=%0d, want sv=%b retired=%0d",
                 sv, retired, vec(3'd4, 4'b0000, 4'b0010, 1'b1, 2'b01), m_retired);
      end
      return;
    end
    op = 4'($urandom); mem_ready = 1'($urandom); #3;
    checks++;
    if (sv !== vec(3'd2, 4'b0000, alu_tab[o[2:0]], 1'b0, 2'b00) || srcv !== src) begin
      errors++;
      $display("FAIL exec op=%b: sv=%b src=%b, want sv=%b src=%b",
               o, sv, srcv, vec(3'd2, 4'b0000, alu_tab[o[2:0]], 1'b0, 2'b00), src);
    end
    step();
    op = 4'($urandom); mem_ready = 1'($urandom); #3;
    checks++;
    if (sv !== vec(3'd3, 4'b0001, alu_tab[o[2:0]], 1'b0, 2'b00) || srcv !== src ||
        reg_dst !== (o != 4'b0111) || retired !== 16'(m_retired)) begin
      errors++;
      $display("FAIL wb op=%b: sv=%b src=%b reg_dst=%b retired=%0d, want sv=%b src=%b reg_dst=%b retired=%0d",
               o, sv, srcv, reg_dst, retired, vec(3'd3, 4'b0001, alu_tab[o[2:0]], 1'b0, 2'b00),
               src, (o != 4'b0111), m_retired);
    end
    step();
    m_retired = (m_retired + 1) % 65536;
    checks++;
    if (state !== 3'd0 || retired !== 16'(m_retired)) begin
      errors++;
      $display("FAIL retire: state=%0d retired=%0d, want state=0 retired=%0d", state, retired, m_retired);
    end
  endtask

  task automatic test_addi();
    run_instr(4'b0111, 0);
  endtask

  task automatic test_alu_ops();
    int base;
    base = m_retired;
    for (int o = 0; o < 7; o++) run_instr(4'(o), 0);
    checks++;
    if (retired !== 16'(base + 7)) begin
      errors++;
      $display("FAIL alu_ops_count: retired=%0d, want %0d", retired, base + 7);
    end
  endtask

  task automatic test_fetch_wait();
    run_instr(4'($urandom_range(0, 7)), 3);
    run_instr(4'($urandom_range(0, 7)), 14);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      run_instr(4'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 4));
  endtask

  task automatic test_reset_exec();
    mem_ready = 1'b1; step();
    op = 4'($urandom_range(0, 7)); step();
    reset = 1'b1; mem_ready = 1'b1; #3;
    checks++;
    if (state !== 3'd2 || {mem_req, ir_write, pc_write, reg_write} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_exec_mask: state=%0d strobes=%b, want state=2 strobes=0000",
               state, {mem_req, ir_write, pc_write, reg_write});
    end
    step();
    m_retired = 0;
    checks++;
    if (state !== 3'd0 || reg_write !== 1'b0 || retired !== 16'd0 || halt_cause !== 2'b00) begin
      errors++;
      $display("FAIL reset_exec_abort: state=%0d reg_write=%b retired=%0d cause=%b, want 0 0 0 00",
               state, reg_write, retired, halt_cause);
    end
    reset = 1'b0;
  endtask

  task automatic test_illegal();
    run_instr(4'($urandom_range(8, 15)), $urandom_range(0, 3));
    for (int i = 0; i < 3; i++) begin
      step(); mem_ready = 1'($urandom); op = 4'($urandom); #3;
      checks++;
      if (sv !== vec(3'd4, 4'b0000, 4'b0010, 1'b1, 2'b01) || retired !== 16'(m_retired)) begin
        errors++;
        $display("FAIL illegal_hold[%0d]: sv=%b retired=%0d", i, sv, retired);
      end
    end
    test_reset();
  endtask

  task automatic test_timeout();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #3;
      checks++;
      if (sv !== vec(3'd0, 4'b1000, 4'b0010, 1'b0, 2'b00)) begin
        errors++;
        $display("FAIL timeout_fetch[%0d]: sv=%b", i, sv);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      #3;
      checks++;
      if (sv !== vec(3'd4, 4'b0000, 4'b0010, 1'b1, 2'b10) || retired !== 16'(m_retired)) begin
        errors++;
        $display("FAIL timeout_halt[%0d]: sv=%b retired=%0d, want sv=%b retired=%0d", i, sv, retired,
                 vec(3'd4, 4'b0000, 4'b0010, 1'b1, 2'b10), m_retired);
      end
      step(); mem_ready = 1'($urandom);
    end
    test_reset();
  endtask

  // CNT_W=2 wraps after four retirements; FETCH_TIMEOUT=1 halts on the first stall.
  task automatic test_small();
    reset2 = 1'b1; mem_ready2 = 1'b1; op2 = 4'd0;
    step(); step();
    reset2 = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      op2 = 4'($urandom_range(0, 7));
      repeat (4) step();
      checks++;
      if (state2 !== 3'd0 || retired2 !== 2'(n % 4)) begin
        errors++;
        $display("FAIL small_wrap[%0d]: state=%0d retired=%0d, want 0 %0d", n, state2, retired2, n % 4);
      end
    end
    mem_ready2 = 1'b0; #3;
    checks++;
    if ({mem_req2, pc_write2, ir_write2} !== 3'b100) begin
      errors++;
      $display("FAIL small_stall: req/pc/ir=%b, want 100", {mem_req2, pc_write2, ir_write2});
    end
    step();
    checks++;
    if (state2 !== 3'd4 || halted2 !== 1'b1 || halt_cause2 !== 2'b10 || mem_req2 !== 1'b0 ||
        retired2 !== 2'(5 % 4)) begin
      errors++;
      $display("FAIL small_timeout: state=%0d halted=%b cause=%b req=%b retired=%0d, want 4 1 10 0 1",
               state2, halted2, halt_cause2, mem_req2, retired2);
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; op = 4'd0;
    reset2 = 1'b1; mem_ready2 = 1'b0; op2 = 4'd0;
    test_reset();
    test_addi();
    test_alu_ops();
    test_fetch_wait();
    test_random();
    test_reset_exec();
    run_instr(4'($urandom_range(0, 7)), 1);
    test_illegal();
    run_instr(4'($urandom_range(0, 7)), 2);
    test_timeout();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
